led_scroll_ctrl: RTL and testbench
==================================

LED_SCROLL_CTRL -- requirements
Module: led_scroll_ctrl

Interface
REQ-001 Parameter NCH, default 4, number of 8-bit-class output channels, legal range 2..16.
REQ-002 Parameter W, default 8, width of each channel.
REQ-003 Parameter DIV, default 4, clock cycles per scroll step, legal range >=1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  1 = run scrolling, 0 = pause.
REQ-007 mode  in  2  00 hold, 01 rotate-up, 10 rotate-down, 11 bounce.
REQ-008 load  in  1  one-cycle request to shift load_data into channel 0.
REQ-009 load_data  in  W  value inserted on load.
REQ-010 lout  out  NCH*W  channel k occupies bits [k*W +: W].
REQ-011 step  out  1  registered pulse, high for the cycle in which a scroll step is applied.
REQ-012 dir  out  1  current scroll direction, 0 = up, 1 = down.

Function
REQ-013 FSM states: IDLE (enable=0) and RUN (enable=1); IDLE->RUN and RUN->IDLE on the edge sampling the new enable value.
REQ-014 Prescaler cnt counts 0..DIV-1 in RUN and wraps to 0; in IDLE it holds its value and does not clear.
REQ-015 A step occurs on the edge where state=RUN and cnt=DIV-1: lout updates and step=1 for the following cycle.
REQ-016 The first step occurs on the DIV-th rising edge at which enable=1 is sampled after reset or load.
REQ-017 Mode 00: step still pulses; lout unchanged.
REQ-018 Mode 01: ch[k]<=ch[k-1] for k>=1, ch[0]<=ch[NCH-1]; dir<=0.
REQ-019 Mode 10: ch[k]<=ch[k+1] for k<=NCH-2, ch[NCH-1]<=ch[0]; dir<=1.
REQ-020 Mode 11: internal position pos (0..NCH-1); effective direction is up if pos=0, down if pos=NCH-1, else dir; rotate as in mode 01 or 10 accordingly, pos +/-1, dir<=effective direction.
REQ-021 pos changes only in mode 11 steps and on load/reset; modes 00/01/10 leave pos unchanged.
REQ-022 load=1 (in any state) has priority over a step: ch[0]<=load_data, ch[k]<=ch[k-1], old ch[NCH-1] discarded, cnt<=0, pos<=0, dir<=0, step<=0.
REQ-023 A mode change takes effect at the next step; cnt is not disturbed.
REQ-024 enable deasserting on the same edge that cnt=DIV-1 suppresses that step.
REQ-025 With DIV=1, a step occurs every RUN cycle.

Reset
REQ-026 rst=1 has priority over load and enable: state IDLE, cnt=0, pos=0, dir=0, step=0.
REQ-027 Reset value of channel k is k+1 (zero-extended to W), giving 0x04030201 at default parameters.
REQ-028 rst asserted mid-run restores all REQ-026/027 values on the next edge; no step pulse is emitted during or on the cycle after reset.

Structure
REQ-029 Package led_scroll_pkg holds the mode encodings (HOLD, ROT_UP, ROT_DN, BOUNCE) and the IDLE/RUN state typedef.
REQ-030 Sub-module step_prescaler (parameter DIV; inputs clk, rst, run, clr; output tick) implements REQ-014..016 and REQ-024; the channel register file, rotation and pos/dir logic stay in led_scroll_ctrl.
REQ-031 All outputs are driven directly from registers.

Verification (NCH=4, W=8, DIV=4)
REQ-032 Reset: rst=1 for 2 cycles -> lout=0x04030201, step=0, dir=0.
REQ-033 Rotate up: mode=01, enable=1 from reset -> step pulses once per 4 cycles; lout goes 0x03020104, then 0x02010403.
REQ-034 Rotate down: mode=10 from reset -> after first step lout=0x01040302 and dir=1.
REQ-035 Bounce: mode=11 from reset -> 3 up-steps, dir=1 after the 3rd, then 3 down-steps return lout to 0x04030201 with dir=0.
REQ-036 Load: in RUN at cnt=2, load=1, load_data=0xAA -> lout=0x030201AA, step=0, next step exactly 4 cycles later.
REQ-037 Pause/reset: enable=0 at cnt=2 for 10 cycles -> lout and cnt frozen, step after 2 more RUN cycles; rst mid-run -> 0x04030201 on the next edge.

Source files
------------

// File: rtl/led_scroll_pkg.sv
// Shared encodings for the LED scroll controller: scroll modes and run/idle FSM states.
package led_scroll_pkg;

   typedef enum logic [1:0] {
      HOLD   = 2'b00,
      ROT_UP = 2'b01,
      ROT_DN = 2'b10,
      BOUNCE = 2'b11
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/step_prescaler.sv
// Divides enabled cycles by DIV; tick is combinational and marks the edge on which a step applies.
// clr restarts the count; the count holds (never clears) while run is low.
module step_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = run && !clr && (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_scroll_ctrl.sv
// Scrolling LED channel register: rotates/bounces NCH channels every DIV enabled cycles, with load insert.
// lout/step/dir are registered and change on the edge a step or load is applied.
module led_scroll_ctrl
   import led_scroll_pkg::*;
#(
   parameter int NCH = 4,
   parameter int W   = 8,
   parameter int DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [W-1:0]     load_data,
   output logic [NCH*W-1:0] lout,
   output logic             step,
   output logic             dir
);

   localparam int PW = $clog2(NCH);
   localparam logic [PW-1:0] POS_MAX = PW'(NCH - 1);

   typedef logic [NCH-1:0][W-1:0] ch_t;

   state_e        state_q, state_d;
   ch_t           ch_q, ch_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          dir_q, dir_d;
   logic          step_q, step_d;
   logic          tick;
   logic          eff_dn;
   ch_t           up_v, dn_v, ld_v;

   step_prescaler #(.DIV(DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .run  (enable),
      .clr  (load),
      .tick (tick)
   );

   assign up_v = {ch_q[NCH-2:0], ch_q[NCH-1]};
   assign dn_v = {ch_q[0], ch_q[NCH-1:1]};
   assign ld_v = {ch_q[NCH-2:0], load_data};

   // Bounce turns around at the ends regardless of the stored direction.
   assign eff_dn = (pos_q == POS_MAX) ? 1'b1 : (pos_q == '0) ? 1'b0 : dir_q;

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      step_d  = 1'b0;

      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (load) begin
         ch_d  = ld_v;
         pos_d = '0;
         dir_d = 1'b0;
      end else if (tick) begin
         step_d = 1'b1;
         unique case (mode_e'(mode))
            HOLD: ;
            ROT_UP: begin
               ch_d  = up_v;
               dir_d = 1'b0;
            end
            ROT_DN: begin
               ch_d  = dn_v;
               dir_d = 1'b1;
            end
            BOUNCE: begin
               ch_d  = eff_dn ? dn_v : up_v;
               pos_d = eff_dn ? pos_q - 1'b1 : pos_q + 1'b1;
               // dir reports the way the next bounce step will go, so it flips on arrival at an end.
               dir_d = (pos_d == POS_MAX) ? 1'b1 : (pos_d == '0) ? 1'b0 : eff_dn;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            ch_q[k] <= W'(k + 1);
         end
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
      end
   end

   assign lout = ch_q;
   assign step = step_q;
   assign dir  = dir_q;

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Directed bench for led_scroll_ctrl at NCH=4, W=8, DIV=4; inputs driven and outputs sampled on negedge.
module tb_led_scroll_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  mode;
   logic        load;
   logic [7:0]  load_data;
   logic [31:0] lout;
   logic        step;
   logic        dir;

   int n_vec = 0;
   int n_err = 0;

   led_scroll_ctrl #(.NCH(4), .W(8), .DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .mode      (mode),
      .load      (load),
      .load_data (load_data),
      .lout      (lout),
      .step      (step),
      .dir       (dir)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One rising edge, then land on the following falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // Four enabled cycles: step must stay low for three and pulse on the fourth.
   task automatic run_to_step(input string tag);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check_vec($sformatf("%s_step%0d", tag, i), {31'b0, step}, {31'b0, (i == 4)});
      end
   endtask

   logic [31:0] bounce_lout [6] = '{32'h03020104, 32'h02010403, 32'h01040302,
                                    32'h02010403, 32'h03020104, 32'h04030201};
   logic        bounce_dir  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      rst = 1'b1; enable = 1'b0; mode = 2'b00; load = 1'b0; load_data = 8'h00;
      do_reset();
      check_vec("rst_lout", lout, 32'h04030201);
      check_vec("rst_step", {31'b0, step}, 32'd0);
      check_vec("rst_dir",  {31'b0, dir},  32'd0);

      // rotate up
      mode = 2'b01; enable = 1'b1;
      run_to_step("up1");
      check_vec("up1_lout", lout, 32'h03020104);
      run_to_step("up2");
      check_vec("up2_lout", lout, 32'h02010403);
      check_vec("up2_dir", {31'b0, dir}, 32'd0);

      // reset mid-run with cnt at its last value
      cyc(); cyc(); cyc();
      rst = 1'b1;
      cyc();
      check_vec("midrst_lout", lout, 32'h04030201);
      check_vec("midrst_step", {31'b0, step}, 32'd0);
      rst = 1'b0;
      cyc();
      check_vec("postrst_step", {31'b0, step}, 32'd0);
      check_vec("postrst_lout", lout, 32'h04030201);

      // rotate down
      enable = 1'b0;
      do_reset();
      mode = 2'b10; enable = 1'b1;
      run_to_step("dn1");
      check_vec("dn1_lout", lout, 32'h01040302);
      check_vec("dn1_dir", {31'b0, dir}, 32'd1);

      // bounce
      enable = 1'b0;
      do_reset();
      mode = 2'b11; enable = 1'b1;
      for (int s = 0; s < 6; s++) begin
         run_to_step($sformatf("bnc%0d", s));
         check_vec($sformatf("bnc%0d_lout", s), lout, bounce_lout[s]);
         check_vec($sformatf("bnc%0d_dir", s), {31'b0, dir}, {31'b0, bounce_dir[s]});
      end

      // load in RUN at cnt=2
      enable = 1'b0;
      do_reset();
      mode = 2'b01; enable = 1'b1;
      cyc(); cyc();
      load = 1'b1; load_data = 8'hAA;
      cyc();
      load = 1'b0; load_data = 8'h00;
      check_vec("ld_lout", lout, 32'h030201AA);
      check_vec("ld_step", {31'b0, step}, 32'd0);
      check_vec("ld_dir", {31'b0, dir}, 32'd0);
      run_to_step("ld_next");
      check_vec("ld_next_lout", lout, 32'h0201AA03);

      // hold mode: step pulses, channels unchanged
      mode = 2'b00;
      run_to_step("hold");
      check_vec("hold_lout", lout, 32'h0201AA03);

      // pause at cnt=2 for 10 cycles
      mode = 2'b01;
      cyc(); cyc();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check_vec($sformatf("pause%0d_step", i), {31'b0, step}, 32'd0);
      end
      check_vec("pause_lout", lout, 32'h0201AA03);
      enable = 1'b1;
      cyc();
      check_vec("resume1_step", {31'b0, step}, 32'd0);
      cyc();
      check_vec("resume2_step", {31'b0, step}, 32'd1);
      check_vec("resume2_lout", lout, 32'h01AA0302);

      // enable dropping on the cnt=DIV-1 edge suppresses that step
      cyc(); cyc(); cyc();
      enable = 1'b0;
      cyc();
      check_vec("supp_step", {31'b0, step}, 32'd0);
      check_vec("supp_lout", lout, 32'h01AA0302);
      enable = 1'b1;
      cyc();
      check_vec("supp_resume_step", {31'b0, step}, 32'd1);
      check_vec("supp_resume_lout", lout, 32'hAA030201);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
